// File: rtl/powerup_controller.sv
// Power-pack pickup, per-player effect timing and respawn sequencing.
// Optional: define PP_SHIELD_CONSUME_EN to let a consume pulse end a shield early.
module powerup_controller #(
    parameter int         PACK_W          = 20,
    parameter int         PACK_H          = 20,
    parameter int         PUCK_SIZE       = 16,
    parameter logic [7:0] EFFECT_FRAMES   = 8'd180,
    parameter logic [7:0] COOLDOWN_FRAMES = 8'd120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [10:0] puck_x,
    input  logic [9:0]  puck_y,
    input  logic        last_hit,
    input  logic [10:0] rx,
    input  logic [9:0]  ry,
    input  logic [1:0]  mode,
    output logic        eaten,
    output logic        spawn,
    output logic [1:0]  fx_shrink,
    output logic [1:0]  fx_boost,
    output logic [1:0]  fx_invert,
    output logic [1:0]  fx_shield,
    output logic [7:0]  frames_left,
    input  logic        consume
);

    typedef enum logic [1:0] {
        ARMED,
        ACTIVE,
        COOLDOWN,
        SPAWN
    } state_t;

    localparam logic [1:0] MODE_SHRINK = 2'b00;
    localparam logic [1:0] MODE_BOOST  = 2'b01;
    localparam logic [1:0] MODE_INVERT = 2'b10;
    localparam logic [1:0] MODE_SHIELD = 2'b11;

    localparam logic [11:0] PW = 12'(PACK_W);
    localparam logic [11:0] PH = 12'(PACK_H);
    localparam logic [11:0] PS = 12'(PUCK_SIZE);

    state_t      state_q;
    state_t      state_n;
    logic [7:0]  timer_q;
    logic [7:0]  timer_n;
    logic [7:0]  cool_q;
    logic [7:0]  cool_n;
    logic [1:0]  mode_q;
    logic [1:0]  mode_n;
    logic        owner_q;
    logic        owner_n;

    logic        eaten_n;
    logic        spawn_n;
    logic [1:0]  shrink_n;
    logic [1:0]  boost_n;
    logic [1:0]  invert_n;
    logic [1:0]  shield_n;
    logic [7:0]  frames_n;

    logic [11:0] px;
    logic [11:0] py;
    logic [11:0] kx;
    logic [11:0] ky;
    logic        overlap;
    logic        shield_end;
    logic        effect_end;
    logic [1:0]  own;
    logic [1:0]  opp;

    // 12-bit sums cannot wrap; strict compares make touching edges a miss
    assign px = {1'b0, puck_x};
    assign py = {2'b00, puck_y};
    assign kx = {1'b0, rx};
    assign ky = {2'b00, ry};

    assign overlap = (px < kx + PW) && (px + PS > kx) &&
                     (py < ky + PH) && (py + PS > ky);

`ifdef PP_SHIELD_CONSUME_EN
    assign shield_end = consume && (mode_q == MODE_SHIELD);
`else
    assign shield_end = consume & 1'b0;
`endif

    assign effect_end = (frame_tick && (timer_q == 8'd1)) || shield_end;

    assign own = owner_q ? 2'b10 : 2'b01;
    assign opp = ~own;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARMED;
            timer_q     <= 8'd0;
            cool_q      <= 8'd0;
            mode_q      <= 2'b00;
            owner_q     <= 1'b0;
            eaten       <= 1'b0;
            spawn       <= 1'b0;
            fx_shrink   <= 2'b00;
            fx_boost    <= 2'b00;
            fx_invert   <= 2'b00;
            fx_shield   <= 2'b00;
            frames_left <= 8'd0;
        end else begin
            state_q     <= state_n;
            timer_q     <= timer_n;
            cool_q      <= cool_n;
            mode_q      <= mode_n;
            owner_q     <= owner_n;
            eaten       <= eaten_n;
            spawn       <= spawn_n;
            fx_shrink   <= shrink_n;
            fx_boost    <= boost_n;
            fx_invert   <= invert_n;
            fx_shield   <= shield_n;
            frames_left <= frames_n;
        end
    end

    always_comb begin
        state_n = state_q;
        timer_n = timer_q;
        cool_n  = cool_q;
        mode_n  = mode_q;
        owner_n = owner_q;
        unique case (state_q)
            ARMED: begin
                if (overlap) begin
                    mode_n  = mode;
                    owner_n = last_hit;
                    timer_n = EFFECT_FRAMES;
                    state_n = ACTIVE;
                end
            end
            ACTIVE: begin
                if (frame_tick) begin
                    timer_n = timer_q - 8'd1;
                end
                if (effect_end) begin
                    timer_n = 8'd0;
                    cool_n  = COOLDOWN_FRAMES;
                    state_n = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (frame_tick) begin
                    cool_n = cool_q - 8'd1;
                    if (cool_q == 8'd1) begin
                        state_n = SPAWN;
                    end
                end
            end
            SPAWN: begin
                state_n = ARMED;
            end
            default: begin
                state_n = ARMED;
            end
        endcase
    end

    // Outputs are a registered decode of the current state, so fx lags eaten
    always_comb begin
        eaten_n  = (state_q == ARMED) && overlap;
        spawn_n  = (state_q == SPAWN);
        shrink_n = 2'b00;
        boost_n  = 2'b00;
        invert_n = 2'b00;
        shield_n = 2'b00;
        frames_n = 8'd0;
        if (state_q == ACTIVE) begin
            frames_n = timer_q;
            unique case (1'b1)
                (mode_q == MODE_SHRINK): shrink_n = opp;
                (mode_q == MODE_BOOST):  boost_n  = own;
                (mode_q == MODE_INVERT): invert_n = opp;
                (mode_q == MODE_SHIELD): shield_n = own;
                default:                 shrink_n = 2'b00;
            endcase
        end
    end

endmodule

// File: tb/tb_powerup_controller.sv
// Directed bench for powerup_controller with short effect/cooldown timers.
// Expectations follow PP_SHIELD_CONSUME_EN when the bench is built with it.
module tb_powerup_controller;

    logic        clk;
    logic        reset;
    logic        frame_tick;
    logic [10:0] puck_x;
    logic [9:0]  puck_y;
    logic        last_hit;
    logic [10:0] rx;
    logic [9:0]  ry;
    logic [1:0]  mode;
    logic        eaten;
    logic        spawn;
    logic [1:0]  fx_shrink;
    logic [1:0]  fx_boost;
    logic [1:0]  fx_invert;
    logic [1:0]  fx_shield;
    logic [7:0]  frames_left;
    logic        consume;

    int checks = 0;
    int errors = 0;

    powerup_controller #(
        .PACK_W(20),
        .PACK_H(20),
        .PUCK_SIZE(16),
        .EFFECT_FRAMES(8'd3),
        .COOLDOWN_FRAMES(8'd2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_tick(frame_tick),
        .puck_x(puck_x),
        .puck_y(puck_y),
        .last_hit(last_hit),
        .rx(rx),
        .ry(ry),
        .mode(mode),
        .eaten(eaten),
        .spawn(spawn),
        .fx_shrink(fx_shrink),
        .fx_boost(fx_boost),
        .fx_invert(fx_invert),
        .fx_shield(fx_shield),
        .frames_left(frames_left),
        .consume(consume)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic no_overlap();
        puck_x = 11'd0;
        puck_y = 10'd0;
    endtask

    task automatic hit();
        puck_x = 11'd690;
        puck_y = 10'd495;
    endtask

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        consume    = 1'b0;
        last_hit   = 1'b0;
        mode       = 2'b00;
        rx         = 11'd700;
        ry         = 10'd500;
        no_overlap();
        step();
        step();
        chk("rst_eaten", 16'(eaten), 16'd0);
        chk("rst_spawn", 16'(spawn), 16'd0);
        chk("rst_fx", {8'd0, fx_shrink, fx_boost, fx_invert, fx_shield}, 16'd0);
        chk("rst_frames", 16'(frames_left), 16'd0);
        reset = 1'b0;
        step();
        step();
        step();
        chk("idle_spawn", 16'(spawn), 16'd0);
        chk("idle_eaten", 16'(eaten), 16'd0);

        // SHRINK taken by P2 hits P1's paddle
        mode     = 2'b00;
        last_hit = 1'b1;
        hit();
        step();
        chk("shr_eaten", 16'(eaten), 16'd1);
        chk("shr_fx_lag", 16'(fx_shrink), 16'd0);
        no_overlap();
        step();
        chk("shr_eaten_1clk", 16'(eaten), 16'd0);
        chk("shr_fx", 16'(fx_shrink), 16'b01);
        chk("shr_frames3", 16'(frames_left), 16'd3);
        tick();
        chk("shr_frames2", 16'(frames_left), 16'd2);
        tick();
        chk("shr_frames1", 16'(frames_left), 16'd1);
        chk("shr_fx_held", 16'(fx_shrink), 16'b01);
        tick();
        chk("shr_fx_clr", 16'(fx_shrink), 16'd0);
        chk("shr_frames0", 16'(frames_left), 16'd0);
        tick();
        chk("cd_spawn_early", 16'(spawn), 16'd0);
        tick();
        chk("cd_spawn", 16'(spawn), 16'd1);
        chk("cd_no_eaten", 16'(eaten), 16'd0);
        step();
        chk("cd_spawn_1clk", 16'(spawn), 16'd0);

        // Touching edges: 684+16 == 700 is not overlap, 685 is
        puck_y = 10'd495;
        puck_x = 11'd680;
        step();
        chk("edge_680", 16'(eaten), 16'd0);
        puck_x = 11'd684;
        step();
        chk("edge_684", 16'(eaten), 16'd0);
        puck_x = 11'd685;
        step();
        chk("edge_685", 16'(eaten), 16'd1);
        no_overlap();
        for (int i = 0; i < 5; i++) tick();
        step();
        chk("edge_back_armed", 16'(spawn), 16'd0);

        // SHIELD for P1, overlap coinciding with a tick, overlap held
        mode       = 2'b11;
        last_hit   = 1'b0;
        hit();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("sh_eaten", 16'(eaten), 16'd1);
        step();
        chk("sh_fx", 16'(fx_shield), 16'b01);
        chk("sh_frames3", 16'(frames_left), 16'd3);
        chk("sh_no_reeat", 16'(eaten), 16'd0);
        tick();
        chk("sh_frames2", 16'(frames_left), 16'd2);
        chk("sh_no_reeat2", 16'(eaten), 16'd0);
        tick();
        chk("sh_frames1", 16'(frames_left), 16'd1);
        tick();
        chk("sh_frames0", 16'(frames_left), 16'd0);
        chk("sh_fx_clr", 16'(fx_shield), 16'd0);
        tick();
        chk("sh_cd_eaten", 16'(eaten), 16'd0);
        no_overlap();
        tick();
        chk("sh_spawn", 16'(spawn), 16'd1);
        step();

        // Shield for P2 with a consume pulse after one tick
        mode     = 2'b11;
        last_hit = 1'b1;
        hit();
        step();
        chk("con_eaten", 16'(eaten), 16'd1);
        no_overlap();
        step();
        chk("con_fx", 16'(fx_shield), 16'b10);
        tick();
        chk("con_frames2", 16'(frames_left), 16'd2);
        consume = 1'b1;
        step();
        consume = 1'b0;
        step();
`ifdef PP_SHIELD_CONSUME_EN
        chk("con_fx_clr", 16'(fx_shield), 16'd0);
        chk("con_frames0", 16'(frames_left), 16'd0);
        tick();
        tick();
        chk("con_spawn", 16'(spawn), 16'd1);
`else
        chk("con_fx_kept", 16'(fx_shield), 16'b10);
        chk("con_frames2b", 16'(frames_left), 16'd2);
        tick();
        chk("con_frames1", 16'(frames_left), 16'd1);
        tick();
        chk("con_fx_end", 16'(fx_shield), 16'd0);
        tick();
        tick();
        chk("con_spawn", 16'(spawn), 16'd1);
`endif
        step();

        // BOOST for P1; mode change while active is ignored; reset mid-effect
        mode     = 2'b01;
        last_hit = 1'b0;
        hit();
        step();
        chk("bst_eaten", 16'(eaten), 16'd1);
        mode     = 2'b10;
        last_hit = 1'b1;
        step();
        chk("bst_fx", 16'(fx_boost), 16'b01);
        chk("bst_no_inv", 16'(fx_invert), 16'd0);
        reset = 1'b1;
        step();
        chk("rst_act_fx", {8'd0, fx_shrink, fx_boost, fx_invert, fx_shield}, 16'd0);
        chk("rst_act_frames", 16'(frames_left), 16'd0);
        reset = 1'b0;
        step();
        chk("rst_act_armed", 16'(eaten), 16'd1);
        chk("rst_act_spawn", 16'(spawn), 16'd0);
        no_overlap();
        step();
        chk("inv_fx", 16'(fx_invert), 16'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/powerup_controller.md
Name: powerup_controller

Overview:
- Sits directly downstream of the power-pack renderer.
- Detects puck/pack overlap and issues the one-cycle `eaten` pulse.
- Latches the pack's mode and the player who last hit the puck, then drives per-player effect flags for a fixed number of frames.
- After a cooldown it pulses `spawn` so the renderer places a new pack.

Parameters:
- PACK_W, 20, pack width in pixels (must match the renderer).
- PACK_H, 20, pack height in pixels.
- PUCK_SIZE, 16, puck square side in pixels.
- EFFECT_FRAMES, 8'd180, frames an effect stays active; must be ≥1.
- COOLDOWN_FRAMES, 8'd120, frames between effect end and respawn; must be ≥1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- frame_tick  input  1  one-cycle pulse per video frame (vsync edge)
- puck_x  input  11  puck left edge
- puck_y  input  10  puck top edge
- last_hit  input  1  last paddle to touch the puck (0=P1, 1=P2)
- rx  input  11  pack left edge, from renderer
- ry  input  10  pack top edge, from renderer
- mode  input  2  pack type (00 SHRINK, 01 BOOST, 10 INVERT, 11 SHIELD)
- eaten  output  1  one-cycle pulse when pack is collected
- spawn  output  1  one-cycle pulse requesting a new pack
- fx_shrink  output  2  bit i: player i's paddle shrunk
- fx_boost  output  2  bit i: player i's puck hits boosted
- fx_invert  output  2  bit i: player i's controls inverted
- fx_shield  output  2  bit i: player i has a shield
- frames_left  output  8  remaining effect frames, for the HUD; 0 when idle
- consume  input  1  shield-deflection pulse; used only with PP_SHIELD_CONSUME_EN

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high, overrides everything):
  - State goes to ARMED, because the renderer already places a pack on reset.
  - All fx_* = 0, eaten = 0, spawn = 0, frames_left = 0, both counters = 0.
- Overlap test is combinational on inputs:
  - Condition: puck_x < rx+PACK_W, puck_x+PUCK_SIZE > rx, puck_y < ry+PACK_H, puck_y+PUCK_SIZE > ry.
  - Sums are zero-extended to 12 bits, so there is no wrap-around.
  - Touching edges do not count as overlap.
- States:
  - ARMED: waits for overlap.
    - On overlap: eaten=1 for exactly one cycle. Latch mode and last_hit. Load timer=EFFECT_FRAMES. Go ACTIVE next cycle.
    - Effect flags assert in the cycle after eaten.
    - If overlap and frame_tick arrive together, overlap wins and the tick is ignored.
  - ACTIVE: applies the latched effect. Owner o = latched last_hit; opponent = ~o.
    - SHRINK sets fx_shrink[~o].
    - BOOST sets fx_boost[o].
    - INVERT sets fx_invert[~o].
    - SHIELD sets fx_shield[o].
    - Exactly one fx bit is high in ACTIVE.
    - Each frame_tick decrements timer. frames_left mirrors timer.
    - The tick that brings timer 1→0 clears all fx bits on the next edge, loads cooldown=COOLDOWN_FRAMES, and goes to COOLDOWN.
    - Overlap is ignored in ACTIVE, since the pack is parked at 0,0.
  - COOLDOWN: fx = 0, frames_left = 0.
    - Each frame_tick decrements cooldown.
    - The tick that brings it 1→0 goes to SPAWN.
  - SPAWN: spawn=1 for exactly one cycle, then unconditionally ARMED. Overlap is not evaluated in SPAWN.
- Latency:
  - Overlap to eaten: 1 clk.
  - eaten to fx: 1 clk.
  - Effect duration: exactly EFFECT_FRAMES ticks.
  - Last effect tick to spawn: COOLDOWN_FRAMES ticks plus 1 clk.
- eaten and spawn are never high in the same cycle.
- mode changes while not ARMED have no effect.
- A reset during ACTIVE or COOLDOWN returns to ARMED immediately with all effects cleared. No spawn is issued.

Optional Feature:
- Macro: PP_SHIELD_CONSUME_EN.
- When defined: in ACTIVE with latched mode SHIELD, a consume=1 cycle ends the effect early, with the same next-edge actions as the timer reaching 0 (fx cleared, cooldown loaded, go COOLDOWN). consume is ignored for other modes and other states. If consume and the final tick coincide, the block transitions once.
- When undefined: the consume port exists but is ignored. The shield lasts the full EFFECT_FRAMES.

Test Plan:
- Reset with EFFECT_FRAMES=3, COOLDOWN_FRAMES=2 → all outputs 0, state ARMED; no spawn pulse.
- rx=700, ry=500, puck_x=690, puck_y=495, mode=00, last_hit=1 → eaten high exactly 1 clk; next clk fx_shrink=2'b01, frames_left=3.
- Continue with 3 frame_ticks → fx_shrink=0 after the 3rd tick. 2 more ticks → spawn high exactly 1 clk, back to ARMED.
- Edge contact puck_x=680 (680+16+4 gap), then puck_x=684 with rx=700 → no eaten at 684 (edges touch), eaten at 685.
- mode=11, last_hit=0, eaten, then frame_tick and overlap held in ACTIVE → fx_shield=2'b01; no second eaten; frames_left counts 3,2,1,0.
- PP_SHIELD_CONSUME_EN defined, SHIELD active, consume pulse after 1 tick → fx_shield=0 next clk, COOLDOWN entered. Same stimulus with the macro undefined → shield persists to tick 3.
